// File: rtl/sync_fifo_stat.sv
// Synchronous FIFO with occupancy count, almost-full/empty flags and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through output; default is registered dout.
module sync_fifo_stat #(
  parameter int DEPTH         = 16,
  parameter int DWIDTH        = 16,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       wr_en,
  input  logic [DWIDTH-1:0]          din,
  input  logic                       rd_en,
  input  logic                       clr_err,
  output logic [DWIDTH-1:0]          dout,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow
);
  localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              ovf_q, ovf_d, udf_q, udf_d;
  logic              wr_acc, rd_acc;

  // Flags are pure decodes of the registered count, so they follow reset directly.
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AFULL_C);
  assign almost_empty = (count_q <= AEMPTY_C);
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (wr_acc) wptr_d = (wptr_q == LAST_PTR) ? '0 : wptr_q + 1'b1;
    if (rd_acc) rptr_d = (rptr_q == LAST_PTR) ? '0 : rptr_q + 1'b1;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // Setting beats clearing when both happen on the same edge.
    ovf_d = (wr_en && full)  || (ovf_q && !clr_err);
    udf_d = (rd_en && empty) || (udf_q && !clr_err);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Storage is not reset; reset only discards entries via the pointers and count.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wptr_q] <= din;
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign dout = empty ? '0 : mem_q[rptr_q];
`else
  logic [DWIDTH-1:0] dout_q, dout_d;

  always_comb begin
    dout_d = dout_q;
    if (rd_acc) dout_d = mem_q[rptr_q];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) dout_q <= '0;
    else       dout_q <= dout_d;
  end

  assign dout = dout_q;
`endif

endmodule

// File: tb/tb_sync_fifo_stat.sv
// Bench for sync_fifo_stat (DEPTH=5, DWIDTH=8): directed vector table, corner sequences
// and a randomized run against a queue-based reference model.
module tb_sync_fifo_stat;
  localparam int DEPTH = 5;
  localparam int DW    = 8;
  localparam int AF    = 4;
  localparam int AE    = 1;

  logic          clk = 1'b0;
  logic          rstn;
  logic          wr_en, rd_en, clr_err;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic          full, empty, almost_full, almost_empty, overflow, underflow;
  logic [2:0]    count;

  sync_fifo_stat #(.DEPTH(DEPTH), .DWIDTH(DW), .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)) dut (
    .clk(clk), .rstn(rstn), .wr_en(wr_en), .din(din), .rd_en(rd_en), .clr_err(clr_err),
    .dout(dout), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: contents as a queue, plus last-popped word and sticky bits.
  logic [DW-1:0] q [$];
  logic [DW-1:0] m_dout;
  logic          m_ovf, m_udf;

  typedef struct {
    logic          wr, rd, clr;
    logic [DW-1:0] din;
    int            cnt;
    logic          full, empty, af, ae, ovf, udf;
    logic [DW-1:0] dout;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] exp_dout();
`ifdef SYNC_FIFO_FWFT_EN
    return (q.size() != 0) ? q[0] : '0;
`else
    return m_dout;
`endif
  endfunction

  task automatic model_reset();
    q.delete();
    m_dout = '0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
  endtask

  // Drive one cycle; model applies the rules against pre-edge occupancy.
  task automatic step(input logic w, input logic r, input logic c, input logic [DW-1:0] d);
    bit fl, em, wa, ra;
    wr_en = w; rd_en = r; clr_err = c; din = d;
    @(posedge clk);
    fl = (q.size() == DEPTH);
    em = (q.size() == 0);
    wa = w && !fl;
    ra = r && !em;
    m_ovf = (w && fl) || (m_ovf && !c);
    m_udf = (r && em) || (m_udf && !c);
    if (ra) m_dout = q.pop_front();
    if (wa) q.push_back(d);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".count"}, int'(count), q.size());
    chk({tag, ".full"},  int'(full),  int'(q.size() == DEPTH));
    chk({tag, ".empty"}, int'(empty), int'(q.size() == 0));
    chk({tag, ".afull"}, int'(almost_full),  int'(q.size() >= AF));
    chk({tag, ".aempty"},int'(almost_empty), int'(q.size() <= AE));
    chk({tag, ".ovf"},   int'(overflow),  int'(m_ovf));
    chk({tag, ".udf"},   int'(underflow), int'(m_udf));
    chk({tag, ".dout"},  int'(dout), int'(exp_dout()));
  endtask

  task automatic do_reset();
    rstn = 1'b0; wr_en = 0; rd_en = 0; clr_err = 0; din = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model("reset");
    rstn = 1'b1;
  endtask

  vec_t tbl [14];

  initial begin
    // wr rd clr din   cnt full empty af ae ovf udf dout
    tbl[0]  = '{1,0,0,8'h11, 1,0,0,0,1,0,0,8'h00};
    tbl[1]  = '{1,0,0,8'h22, 2,0,0,0,0,0,0,8'h00};
    tbl[2]  = '{1,0,0,8'h33, 3,0,0,0,0,0,0,8'h00};
    tbl[3]  = '{1,0,0,8'h44, 4,0,0,1,0,0,0,8'h00};
    tbl[4]  = '{1,0,0,8'h55, 5,1,0,1,0,0,0,8'h00};
    tbl[5]  = '{1,0,0,8'h66, 5,1,0,1,0,1,0,8'h00};
    tbl[6]  = '{0,0,1,8'h00, 5,1,0,1,0,0,0,8'h00};
    tbl[7]  = '{0,1,0,8'h00, 4,0,0,1,0,0,0,8'h11};
    tbl[8]  = '{0,1,0,8'h00, 3,0,0,0,0,0,0,8'h22};
    tbl[9]  = '{0,1,0,8'h00, 2,0,0,0,0,0,0,8'h33};
    tbl[10] = '{0,1,0,8'h00, 1,0,0,0,1,0,0,8'h44};
    tbl[11] = '{0,1,0,8'h00, 0,0,1,0,1,0,0,8'h55};
    tbl[12] = '{0,1,0,8'h00, 0,0,1,0,1,0,1,8'h55};
    tbl[13] = '{0,0,1,8'h00, 0,0,1,0,1,0,0,8'h55};

    do_reset();

    // Directed table: fill, overflow, clear, drain, underflow, clear.
    for (int i = 0; i < 14; i++) begin
      string t;
      t = $sformatf("tbl%0d", i);
      step(tbl[i].wr, tbl[i].rd, tbl[i].clr, tbl[i].din);
      chk({t, ".count"}, int'(count), tbl[i].cnt);
      chk({t, ".full"},  int'(full),  int'(tbl[i].full));
      chk({t, ".empty"}, int'(empty), int'(tbl[i].empty));
      chk({t, ".afull"}, int'(almost_full),  int'(tbl[i].af));
      chk({t, ".aempty"},int'(almost_empty), int'(tbl[i].ae));
      chk({t, ".ovf"},   int'(overflow),  int'(tbl[i].ovf));
      chk({t, ".udf"},   int'(underflow), int'(tbl[i].udf));
`ifndef SYNC_FIFO_FWFT_EN
      chk({t, ".dout"},  int'(dout), int'(tbl[i].dout));
`endif
    end

    // Simultaneous read/write at count 3 across pointer wrap.
    for (int i = 0; i < 3; i++) step(1, 0, 0, 8'h80 + 8'(i));
    check_model("pre_rw");
    for (int i = 0; i < 12; i++) begin
      step(1, 1, 0, 8'h83 + 8'(i));
      check_model($sformatf("rw%0d", i));
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 8'h00);
      check_model($sformatf("rwdrain%0d", i));
    end

    // Set and clear on the same edge: set must win.
    for (int i = 0; i < 5; i++) step(1, 0, 0, 8'hC0 + 8'(i));
    step(1, 0, 1, 8'hEE);
    chk("ovf_set_wins", int'(overflow), 1);
    check_model("ovf_set_wins");
    step(0, 0, 1, 8'h00);
    check_model("ovf_clr");

    // Full with simultaneous read+write: write rejected, read accepted.
    step(1, 1, 0, 8'hDD);
    chk("full_rw.count", int'(count), 4);
    check_model("full_rw");
    for (int i = 0; i < 4; i++) step(0, 1, 0, 8'h00);
    // Empty with simultaneous read+write: read rejected, write accepted.
    step(1, 1, 1, 8'h5A);
    chk("empty_rw.count", int'(count), 1);
    check_model("empty_rw");
    step(0, 1, 1, 8'h00);
    check_model("empty_rw_pop");

`ifdef SYNC_FIFO_FWFT_EN
    step(1, 0, 1, 8'hA5);
    chk("fwft.dout",  int'(dout), 8'hA5);
    chk("fwft.empty", int'(empty), 0);
    step(0, 1, 0, 8'h00);
    chk("fwft_pop.empty", int'(empty), 1);
    chk("fwft_pop.dout",  int'(dout), 0);
`endif

    // Asynchronous reset between edges at count 3 with non-zero dout.
    step(1, 0, 1, 8'h71);
    step(1, 0, 0, 8'h72);
    step(1, 0, 0, 8'h73);
    step(1, 1, 0, 8'h74);
    check_model("pre_async");
    #2;
    rstn = 1'b0;
    #1;
    model_reset();
    chk("async.count", int'(count), 0);
    chk("async.empty", int'(empty), 1);
    chk("async.dout",  int'(dout), 0);
    check_model("async");
    @(posedge clk);
    #1;
    rstn = 1'b1;
    // First write accepted on the first edge after release.
    step(1, 0, 0, 8'h99);
    chk("post_rst.count", int'(count), 1);
    check_model("post_rst");

    // Randomized traffic with shifting bias to visit full and empty.
    for (int i = 0; i < 400; i++) begin
      int wb, rb;
      wb = ((i / 50) % 2 == 0) ? 70 : 30;
      rb = 100 - wb;
      step(($urandom_range(0, 99) < wb), ($urandom_range(0, 99) < rb),
           ($urandom_range(0, 99) < 8), DW'($urandom));
      check_model($sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sync_fifo_stat.md
SYNC_FIFO_STAT -- requirements
Module: sync_fifo_stat

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning number of entries; any integer >= 2, power of two not required.
REQ-002 The block SHALL have parameter DWIDTH, default 16, meaning data width in bits.
REQ-003 The block SHALL have parameter AFULL_THRESH, default DEPTH-2, meaning the occupancy at or above which almost_full asserts; legal range 1..DEPTH.
REQ-004 The block SHALL have parameter AEMPTY_THRESH, default 2, meaning the occupancy at or below which almost_empty asserts; legal range 0..DEPTH-1.
REQ-005 The block SHALL have port clk, input, width 1: the single clock; all logic is rising-edge.
REQ-006 The block SHALL have port rstn, input, width 1: reset, asynchronous, active-low.
REQ-007 The block SHALL have port wr_en, input, width 1: write request.
REQ-008 The block SHALL have port din, input, width DWIDTH: write data.
REQ-009 The block SHALL have port rd_en, input, width 1: read or pop request.
REQ-010 The block SHALL have port clr_err, input, width 1: synchronous clear of the sticky error flags.
REQ-011 The block SHALL have port dout, output, width DWIDTH: read data.
REQ-012 The block SHALL have ports full, empty, almost_full and almost_empty, each an output of width 1: the status flags.
REQ-013 The block SHALL have port count, output, width $clog2(DEPTH+1): current occupancy.
REQ-014 The block SHALL have ports overflow and underflow, each an output of width 1: sticky error flags.

Function
REQ-015 The block SHALL make all DEPTH entries usable: full = (count == DEPTH) and empty = (count == 0).
REQ-016 A write SHALL be accepted iff wr_en && !full; an accepted write stores din at wptr and advances wptr.
REQ-017 A read SHALL be accepted iff rd_en && !empty; an accepted read advances rptr.
REQ-018 wptr and rptr SHALL wrap from DEPTH-1 to 0 explicitly, independent of whether DEPTH is a power of two.
REQ-019 count SHALL change by +1 on a write-only cycle, by -1 on a read-only cycle, and be unchanged when both or neither are accepted.
REQ-020 When both wr_en and rd_en are high and count is strictly between 0 and DEPTH, both operations SHALL be accepted.
REQ-021 When full, a write SHALL be rejected even with a simultaneous accepted read.
REQ-022 When empty, a read SHALL be rejected even with a simultaneous accepted write.
REQ-023 almost_full SHALL equal (count >= AFULL_THRESH) and almost_empty SHALL equal (count <= AEMPTY_THRESH), both decoded from the registered count.
REQ-024 overflow SHALL set on any edge with wr_en && full.
REQ-025 underflow SHALL set on any edge with rd_en && empty.
REQ-026 overflow and underflow SHALL hold until an edge with clr_err high; when set and clear occur on the same edge, set SHALL win.
REQ-027 A rejected operation SHALL not modify memory, pointers, count or dout.

Reset
REQ-028 While rstn is low, wptr, rptr and count SHALL be 0, dout SHALL be 0, empty and almost_empty SHALL be 1, and full, almost_full, overflow and underflow SHALL be 0.
REQ-029 Reset asserted mid-operation SHALL discard all stored entries immediately; memory contents need not be cleared.
REQ-030 The first accepted write SHALL be possible on the first rising edge after rstn deasserts.

Configuration
REQ-031 With macro SYNC_FIFO_FWFT_EN undefined (standard mode), dout SHALL be registered: it loads the entry at rptr on the edge that accepts a read, giving 1-cycle read latency, and holds otherwise.
REQ-032 With SYNC_FIFO_FWFT_EN defined (first-word-fall-through mode), dout SHALL show the entry at rptr combinationally whenever !empty and 0 when empty; rd_en pops that word.
REQ-033 In FWFT mode, a word written into an empty FIFO at edge N SHALL be visible on dout immediately after edge N, together with empty deasserting.
REQ-034 All other requirements SHALL hold identically in both modes.

Verification (DEPTH=5, DWIDTH=8, AFULL_THRESH=4, AEMPTY_THRESH=1)
REQ-035 Bench scenario: reset, then write 0x11..0x55 on 5 edges -> count 5, full=1, almost_full asserted from count 4, empty=0.
REQ-036 Bench scenario: from full, pulse wr_en with din=0x66 -> overflow=1, count stays 5, contents unchanged; then clr_err pulse -> overflow=0.
REQ-037 Bench scenario: read 5 times in standard mode -> dout 0x11,0x22,0x33,0x44,0x55, each one cycle after its read edge; empty=1 after the fifth read; a sixth rd_en -> underflow=1.
REQ-038 Bench scenario: at count 3, hold wr_en and rd_en high for 12 edges with an incrementing din -> count stays 3, pointers wrap at 4->0, and output order is preserved.
REQ-039 Bench scenario: FWFT build, write 0xA5 into an empty FIFO -> dout=0xA5 and empty=0 right after the edge; rd_en for one edge -> empty=1 and dout=0.
REQ-040 Bench scenario: drop rstn asynchronously between edges at count 3 -> count=0, empty=1 and dout=0 without any clock edge.
